sl_preceptron_stream_packer: RTL and testbench

Upstream feeder for the perceptron top. It accepts a byte-serial input stream with a valid/ready handshake and packs bytes into DATA_IN_LANES-wide words on `data_valid`/`data_in`. It enforces exactly VECTOR_LENGTH bytes per vector by zero-padding short vectors and discarding excess bytes of long ones. It inserts a fixed idle gap between vectors so the downstream FIFO and MAC can hand over the weight memory.

---
 rtl/sl_preceptron_stream_packer.sv | 198 +++++++++++++++++++
 tb/tb_sl_preceptron_stream_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sl_preceptron_stream_packer.sv
// Byte-serial to DATA_IN_LANES-wide word packer that forces each vector to exactly VECTOR_LENGTH bytes.
// Define SL_PRECEPTRON_PACKER_STATS_EN to build the sticky error flags and the vector counter.
module sl_preceptron_stream_packer #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int DATA_IN_LANES = 4,
  parameter int VECTOR_LENGTH = 64,
  parameter int GAP_CYCLES    = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [DATA_IN_WIDTH-1:0]               s_data,
  input  logic                                   s_last,
  output logic                                   data_valid,
  output logic [DATA_IN_WIDTH*DATA_IN_LANES-1:0] data_in,
  input  logic                                   err_clr,
  output logic                                   err_short,
  output logic                                   err_long,
  output logic [15:0]                            vec_count
);

  localparam int NW  = VECTOR_LENGTH / DATA_IN_LANES;
  localparam int LW  = (DATA_IN_LANES > 1) ? $clog2(DATA_IN_LANES) : 1;
  localparam int BW  = $clog2(VECTOR_LENGTH + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_PACK = 2'd0,
    ST_PAD  = 2'd1,
    ST_DROP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef logic [DATA_IN_LANES-1:0][DATA_IN_WIDTH-1:0] word_t;

  // Handshake: a byte transfers on any rising edge where s_valid && s_ready;
  // s_ready depends only on registered state, never on s_valid.
  state_t          state_q, state_d;
  logic            rdy_en_q;
  logic [LW-1:0]   lane_q, lane_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [WCW-1:0]  word_q, word_d;
  logic [GW-1:0]   gap_q, gap_d;
  word_t           buf_q, buf_d;
  word_t           word_v;
  logic            dv_q, dv_d;
  word_t           dout_q, dout_d;
  logic            accept;
  logic            end_vec;
  logic            set_short, set_long, inc_vec;

  assign s_ready    = rdy_en_q && ((state_q == ST_PACK) || (state_q == ST_DROP));
  assign accept     = s_valid && s_ready;
  assign data_valid = dv_q;
  assign data_in    = dout_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    byte_d    = byte_q;
    word_d    = word_q;
    gap_d     = gap_q;
    buf_d     = buf_q;
    dv_d      = 1'b0;
    dout_d    = dout_q;
    end_vec   = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    inc_vec   = 1'b0;
    word_v    = buf_q;
    case (state_q)
      ST_PACK: begin
        if (accept) begin
          word_v[lane_q] = s_data;
          byte_d         = byte_q + BW'(1);
          if ((byte_q == BW'(VECTOR_LENGTH - 1)) || (lane_q == LW'(DATA_IN_LANES - 1)) || s_last) begin
            // Lanes above the current one are already zero because buf is cleared on every emit.
            dv_d   = 1'b1;
            dout_d = word_v;
            buf_d  = '0;
            lane_d = '0;
            word_d = word_q + WCW'(1);
            if (byte_q == BW'(VECTOR_LENGTH - 1)) begin
              inc_vec = 1'b1;
              if (s_last) begin
                end_vec = 1'b1;
              end else begin
                set_long = 1'b1;
                state_d  = ST_DROP;
                byte_d   = '0;
                word_d   = '0;
              end
            end else if (s_last) begin
              set_short = 1'b1;
              if (word_q < WCW'(NW - 1)) begin
                state_d = ST_PAD;
              end else begin
                inc_vec = 1'b1;
                end_vec = 1'b1;
              end
            end
          end else begin
            buf_d  = word_v;
            lane_d = lane_q + LW'(1);
          end
        end
      end
      ST_PAD: begin
        dv_d   = 1'b1;
        dout_d = '0;
        word_d = word_q + WCW'(1);
        if (word_q == WCW'(NW - 1)) begin
          inc_vec = 1'b1;
          end_vec = 1'b1;
        end
      end
      ST_DROP: begin
        if (accept && s_last) begin
          end_vec = 1'b1;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = ST_PACK;
          gap_d   = '0;
        end
      end
      default: state_d = ST_PACK;
    endcase
    if (end_vec) begin
      state_d = (GAP_CYCLES == 0) ? ST_PACK : ST_GAP;
      byte_d  = '0;
      word_d  = '0;
      lane_d  = '0;
      gap_d   = '0;
      buf_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PACK;
      rdy_en_q <= 1'b0;
      lane_q   <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      gap_q    <= '0;
      buf_q    <= '0;
      dv_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      lane_q   <= lane_d;
      byte_q   <= byte_d;
      word_q   <= word_d;
      gap_q    <= gap_d;
      buf_q    <= buf_d;
      dv_q     <= dv_d;
      dout_q   <= dout_d;
    end
  end

`ifdef SL_PRECEPTRON_PACKER_STATS_EN
  logic        err_short_q, err_long_q;
  logic [15:0] vec_q;

  // Set and increment take priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      vec_q       <= '0;
    end else begin
      if (set_short)    err_short_q <= 1'b1;
      else if (err_clr) err_short_q <= 1'b0;
      if (set_long)     err_long_q  <= 1'b1;
      else if (err_clr) err_long_q  <= 1'b0;
      if (inc_vec)      vec_q       <= vec_q + 16'd1;
      else if (err_clr) vec_q       <= '0;
    end
  end

  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign vec_count = vec_q;
`else
  logic unused_stats;
  assign unused_stats = ^{err_clr, set_short, set_long, inc_vec};
  assign err_short    = 1'b0;
  assign err_long     = 1'b0;
  assign vec_count    = '0;
`endif

endmodule

// File: tb/tb_sl_preceptron_stream_packer.sv
// Bench for sl_preceptron_stream_packer: directed vectors checked against a vector-level packing model.
module tb_sl_preceptron_stream_packer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int VL = 64;
  localparam int NW = VL / L;
  localparam int GC = 4;
`ifdef SL_PRECEPTRON_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic            data_valid;
  logic [DW*L-1:0] data_in;
  logic            err_clr = 1'b0;
  logic            err_short;
  logic            err_long;
  logic [15:0]     vec_count;

  always #5 clk = ~clk;

  sl_preceptron_stream_packer #(
    .DATA_IN_WIDTH(DW), .DATA_IN_LANES(L), .VECTOR_LENGTH(VL), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .data_valid(data_valid), .data_in(data_in), .err_clr(err_clr),
    .err_short(err_short), .err_long(err_long), .vec_count(vec_count)
  );

  // scoreboard
  logic [DW*L-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_vec = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word k of a vector whose byte i is (base+i) and which carries n bytes:
  // bytes past n are padding zeros, bytes past VL never appear.
  function automatic logic [DW*L-1:0] model_word(input int base, input int n, input int k);
    logic [DW*L-1:0] w;
    w = '0;
    for (int j = 0; j < L; j++) begin
      if ((k * L + j) < n && (k * L + j) < VL) w[j*DW +: DW] = DW'(base + k * L + j);
    end
    return w;
  endfunction

  task automatic push_words(input int base, input int n, input int nw);
    for (int k = 0; k < nw; k++) exp_q.push_back(model_word(base, n, k));
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_strobe: got data_valid=1 data_in=0x%0h expected no strobe at %0t", data_in, $time);
      end else begin
        check("data_in", data_in, exp_q.pop_front());
      end
    end
  end

  // driver tasks; called at posedge+1
  task automatic send_bytes(input int base, input int n, input bit with_last, input int bubble_pct);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < bubble_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      s_last  = with_last && (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        t++;
        if (t > 200) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout: got no s_ready for byte %0d expected acceptance within 200 cycles", i);
          break;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_gap(input string name, input int exp_low);
    int cnt;
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (s_ready) break;
      cnt++;
    end
    check(name, cnt, exp_low);
    @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_stats(input string name, input bit e_short, input bit e_long);
    check({name, "_err_short"}, err_short, STATS & e_short);
    check({name, "_err_long"}, err_long, STATS & e_long);
    check({name, "_vec_count"}, vec_count, STATS ? 32'(exp_vec) : 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    // model pinned to hand-computed words
    check("model_first", model_word(0, 64, 0), 32'h03020100);
    check("model_last", model_word(0, 64, 15), 32'h3F3E3D3C);
    check("model_short", model_word(0, 5, 1), 32'h00000004);
    check("model_long", model_word(8'h40, 70, 15), 32'h7F7E7D7C);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_in", data_in, 0);
    check_stats("rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready_pre", s_ready, 0);
    @(negedge clk);
    check("rel_s_ready_post", s_ready, 1);
    @(posedge clk);
    #1;

    // exact vector 0x00..0x3F
    push_words(0, 64, NW);
    send_bytes(0, 64, 1, 0);
    exp_vec++;
    expect_gap("exact_gap", GC);
    check_stats("exact", 0, 0);

    // short vector: 2 data words, 14 pad words, then the gap
    push_words(0, 5, NW);
    send_bytes(0, 5, 1, 0);
    exp_vec++;
    expect_gap("short_gap", (NW - 2) + GC);
    check_stats("short", 1, 0);

    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_vec = 0;
    check_stats("clr", 0, 0);

    // long vector: 70 bytes, last 6 dropped
    push_words(8'h40, 70, NW);
    send_bytes(8'h40, 70, 1, 0);
    exp_vec++;
    expect_gap("long_gap", GC);
    check_stats("long", 0, 1);

    // following vector with random s_valid bubbles
    push_words(8'h80, 64, NW);
    send_bytes(8'h80, 64, 1, 35);
    exp_vec++;
    expect_gap("bubble_gap", GC);
    check_stats("bubble", 0, 1);

    // reset lands on the second word's strobe; it must vanish at once
    push_words(0, 8, 1);
    send_bytes(0, 8, 0, 0);
    check("pre_rst_valid", data_valid, 1);
    check("pre_rst_word", data_in, model_word(0, 8, 1));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_drain", exp_q.size(), 0);
    exp_vec = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_stats("post_rst", 0, 0);
    push_words(0, 64, NW);
    send_bytes(0, 64, 1, 0);
    exp_vec++;
    expect_gap("fresh_gap", GC);
    check_stats("fresh", 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
